// File: rtl/fc_bus_pkg.sv
// Shared definitions for the fully-connected unit's bus responder:
// field widths and the responder state encoding.
package fc_bus_pkg;

  // Default bus word-address width.
  localparam int ADDR_LEN = 28;

  // Transaction id width carried on the user channels.
  localparam int ID_W = 4;

  // Burst length field width (beats-1, so 1..16 beats).
  localparam int LEN_W = 4;

  // Responder FSM states. Writes go IDLE->WR_BURST->WR_DONE->IDLE and
  // reads go IDLE->RD_BURST->RD_DRAIN->IDLE.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BURST = 3'd1,
    WR_DONE  = 3'd2,
    RD_BURST = 3'd3,
    RD_DRAIN = 3'd4
  } resp_state_t;

  // True when a beat counter holding beats-remaining-minus-one has hit its
  // final beat.
  function automatic logic is_last_beat(input logic [LEN_W-1:0] cnt);
    return (cnt == '0);
  endfunction

endpackage

// File: rtl/fc_sram.sv
// Single-port synchronous word RAM with per-byte write enables and a
// one-cycle registered read port. The array itself is never cleared; only
// the read-data register returns to zero on reset.
module fc_sram
  import fc_bus_pkg::*;
#(
  parameter int width = 32,
  parameter int depth = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       we,
  input  logic [width/8-1:0]         be,
  input  logic [$clog2(depth)-1:0]   addr,
  input  logic [width-1:0]           wdata,
  output logic [width-1:0]           q
);

  localparam int BYTES = width / 8;

  logic [width-1:0] mem [depth];

  // Byte-masked write; a beat with no enabled bytes leaves the word untouched.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered read: data appears the cycle after the read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en && !we) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/fc_mem_responder.sv
// Memory-slave responder behind the FC bus. Accepts incrementing write
// bursts into an on-chip RAM and serves incrementing read bursts with
// rid/rlast. Only one burst is active at a time because the RAM is
// single-ported; the idle channel's address handshake is held off.
//
// Handshake rules (valid/ready): a transfer happens on a rising clk edge
// where both valid and ready are high. Address channels: ready is high only
// in IDLE and only for the arbitration winner. Write data: wready is high
// for the whole WR_BURST state. Read data has no backpressure: every cycle
// with rvalid high is a delivered beat.
module fc_mem_responder
  import fc_bus_pkg::*;
#(
  parameter int word_len  = 32,
  parameter int mem_depth = 4096,
  parameter int addr_len  = ADDR_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  // write address channel
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [addr_len-1:0]   awaddr,
  input  logic [LEN_W-1:0]      awlen,
  input  logic [ID_W-1:0]       awuser_id,
  input  logic                  awuser_ap,
  // write data channel
  input  logic                  wvalid,
  input  logic [word_len-1:0]   wdata,
  input  logic [word_len/8-1:0] wstrb,
  output logic                  wready,
  output logic [ID_W-1:0]       wuser_id,
  output logic                  wuser_last,
  // read address channel
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [addr_len-1:0]   araddr,
  input  logic [LEN_W-1:0]      arlen,
  input  logic [ID_W-1:0]       aruser_id,
  input  logic                  aruser_ap,
  // read data channel
  output logic                  rvalid,
  output logic [word_len-1:0]   rdata,
  output logic                  rlast,
  output logic [ID_W-1:0]       rid,
  // observability
  output logic [2:0]            dbg_state,
  output logic                  dbg_ap,
  output logic [addr_len-1:0]   dbg_addr
);

  localparam int IDX_W = $clog2(mem_depth);

  resp_state_t          state;
  logic                 favour_wr;   // tie-break: 1 = write wins next tie
  logic [addr_len-1:0]  addr_q;      // current beat address (full width)
  logic [LEN_W-1:0]     beat_cnt;    // beats remaining minus one
  logic [ID_W-1:0]      id_q;
  logic                 ap_q;

  logic idle;
  logic aw_hs;
  logic ar_hs;
  logic wr_fire;
  logic rd_issue;
  logic ram_en;

  // Address-channel arbitration: single requester wins, a tie goes to the
  // channel that was not granted last.
  assign idle    = (state == IDLE);
  assign awready = idle && awvalid && (!arvalid || favour_wr);
  assign arready = idle && arvalid && (!awvalid || !favour_wr);
  assign aw_hs   = awvalid && awready;
  assign ar_hs   = arvalid && arready;

  assign wready   = (state == WR_BURST);
  assign wr_fire  = wready && wvalid;
  assign rd_issue = (state == RD_BURST);
  assign ram_en   = wr_fire || rd_issue;

  assign dbg_state = state;
  assign dbg_ap    = ap_q;
  assign dbg_addr  = addr_q;

  // High address bits are ignored: the RAM index is the low bits of the
  // running address, so bursts wrap at the top of the memory.
  fc_sram #(
    .width (word_len),
    .depth (mem_depth)
  ) u_sram (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en),
    .we    (wr_fire),
    .be    (wstrb),
    .addr  (addr_q[IDX_W-1:0]),
    .wdata (wdata),
    .q     (rdata)
  );

  // Responder FSM, burst counters and the read-valid pipeline that tracks
  // the one-cycle RAM latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      favour_wr  <= 1'b1;
      addr_q     <= '0;
      beat_cnt   <= '0;
      id_q       <= '0;
      ap_q       <= 1'b0;
      wuser_last <= 1'b0;
      wuser_id   <= '0;
      rvalid     <= 1'b0;
      rlast      <= 1'b0;
      rid        <= '0;
    end else begin
      wuser_last <= 1'b0;
      rvalid     <= rd_issue;
      rlast      <= rd_issue && is_last_beat(beat_cnt);
      if (rd_issue) begin
        rid <= id_q;
      end

      case (state)
        IDLE: begin
          if (aw_hs) begin
            addr_q    <= awaddr;
            beat_cnt  <= awlen;
            id_q      <= awuser_id;
            ap_q      <= awuser_ap;
            favour_wr <= 1'b0;
            state     <= WR_BURST;
          end else if (ar_hs) begin
            addr_q    <= araddr;
            beat_cnt  <= arlen;
            id_q      <= aruser_id;
            ap_q      <= aruser_ap;
            favour_wr <= 1'b1;
            state     <= RD_BURST;
          end
        end

        WR_BURST: begin
          if (wr_fire) begin
            addr_q   <= addr_q + 1'b1;
            beat_cnt <= beat_cnt - 1'b1;
            if (is_last_beat(beat_cnt)) begin
              wuser_last <= 1'b1;
              wuser_id   <= id_q;
              state      <= WR_DONE;
            end
          end
        end

        WR_DONE: begin
          state <= IDLE;
        end

        RD_BURST: begin
          addr_q   <= addr_q + 1'b1;
          beat_cnt <= beat_cnt - 1'b1;
          if (is_last_beat(beat_cnt)) begin
            state <= RD_DRAIN;
          end
        end

        // Final beat is on the bus this cycle; nothing more in flight.
        RD_DRAIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_mem_responder.sv
// Directed bench for fc_mem_responder: burst write/readback, byte strobes,
// arbitration ties, address wrap, write stalls and reset during a read.
module tb_fc_mem_responder;
  import fc_bus_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 4096;

  logic        clk;
  logic        rst;
  logic        awvalid;
  logic        awready;
  logic [27:0] awaddr;
  logic [3:0]  awlen;
  logic [3:0]  awuser_id;
  logic        awuser_ap;
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wready;
  logic [3:0]  wuser_id;
  logic        wuser_last;
  logic        arvalid;
  logic        arready;
  logic [27:0] araddr;
  logic [3:0]  arlen;
  logic [3:0]  aruser_id;
  logic        aruser_ap;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rlast;
  logic [3:0]  rid;
  logic [2:0]  dbg_state;
  logic        dbg_ap;
  logic [27:0] dbg_addr;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] wq[$];     // write data to drive
  logic [W-1:0] exp_q[$];  // expected read data

  fc_mem_responder #(
    .word_len  (W),
    .mem_depth (DEPTH),
    .addr_len  (28)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .awvalid    (awvalid),
    .awready    (awready),
    .awaddr     (awaddr),
    .awlen      (awlen),
    .awuser_id  (awuser_id),
    .awuser_ap  (awuser_ap),
    .wvalid     (wvalid),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wready     (wready),
    .wuser_id   (wuser_id),
    .wuser_last (wuser_last),
    .arvalid    (arvalid),
    .arready    (arready),
    .araddr     (araddr),
    .arlen      (arlen),
    .aruser_id  (aruser_id),
    .aruser_ap  (aruser_ap),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .rlast      (rlast),
    .rid        (rid),
    .dbg_state  (dbg_state),
    .dbg_ap     (dbg_ap),
    .dbg_addr   (dbg_addr)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one write burst from wq; optionally drops wvalid for stall_cycles
  // cycles before beat stall_beat (junk data on the bus meanwhile).
  task automatic write_burst(input logic [27:0] a, input logic [3:0] len, input logic [3:0] id,
                             input logic [3:0] strb, input int stall_beat, input int stall_cycles);
    awaddr = a; awlen = len; awuser_id = id; awuser_ap = 1'b1; awvalid = 1'b1;
    #1;
    for (int i = 0; i < 20 && awready !== 1'b1; i++) tick();
    check("aw_ready", awready, 1'b1);
    tick();
    awvalid = 1'b0;
    check("wr_state", dbg_state, WR_BURST);
    for (int beat = 0; beat <= int'(len); beat++) begin
      if (beat == stall_beat) begin
        for (int s = 0; s < stall_cycles; s++) begin
          wvalid = 1'b0; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
          check("wready_stall", wready, 1'b1);
          tick();
        end
      end
      wvalid = 1'b1; wdata = wq.pop_front(); wstrb = strb;
      check("wready", wready, 1'b1);
      check("ar_holdoff", arready, 1'b0);
      check("wlast_early", wuser_last, 1'b0);
      tick();
    end
    wvalid = 1'b0;
    arvalid = 1'b0;
    check("wuser_last", wuser_last, 1'b1);
    check("wuser_id", wuser_id, id);
    check("wr_done_state", dbg_state, WR_DONE);
    tick();
    check("wuser_last_pulse", wuser_last, 1'b0);
    check("wr_idle", dbg_state, IDLE);
  endtask

  // Drives one read burst and checks each returned beat against exp_q.
  task automatic read_burst(input logic [27:0] a, input logic [3:0] len, input logic [3:0] id);
    araddr = a; arlen = len; aruser_id = id; aruser_ap = 1'b0; arvalid = 1'b1;
    #1;
    for (int i = 0; i < 20 && arready !== 1'b1; i++) tick();
    check("ar_ready", arready, 1'b1);
    tick();
    arvalid = 1'b0;
    check("rvalid_lat1", rvalid, 1'b0);
    tick();
    for (int beat = 0; beat <= int'(len); beat++) begin
      check("rvalid", rvalid, 1'b1);
      check("rdata", rdata, exp_q.pop_front());
      check("rid", rid, id);
      check("rlast", rlast, (beat == int'(len)) ? 1'b1 : 1'b0);
      tick();
    end
    check("rvalid_end", rvalid, 1'b0);
    check("rd_idle", dbg_state, IDLE);
  endtask

  initial begin
    rst = 1'b1;
    awvalid = 0; awaddr = '0; awlen = '0; awuser_id = '0; awuser_ap = 0;
    wvalid = 0; wdata = '0; wstrb = '0;
    arvalid = 0; araddr = '0; arlen = '0; aruser_id = '0; aruser_ap = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", awready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_wuser_last", wuser_last, 1'b0);
    check("rst_wuser_id", wuser_id, 4'h0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rlast", rlast, 1'b0);
    check("rst_rid", rid, 4'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    tick();

    // first tie after reset goes to write; read stays held off during the burst
    awvalid = 1'b1; arvalid = 1'b1; araddr = 28'h10; arlen = 4'd3; aruser_id = 4'd2;
    #1;
    check("tie1_awready", awready, 1'b1);
    check("tie1_arready", arready, 1'b0);
    wq = '{32'h1, 32'h2, 32'h3, 32'h4};
    write_burst(28'h10, 4'd3, 4'd5, 4'hF, -1, 0);

    // next tie goes to read
    awvalid = 1'b1; arvalid = 1'b1;
    #1;
    check("tie2_arready", arready, 1'b1);
    check("tie2_awready", awready, 1'b0);
    awvalid = 1'b0;
    exp_q = '{32'h1, 32'h2, 32'h3, 32'h4};
    read_burst(28'h10, 4'd3, 4'd2);

    // byte strobes: 0x11223344 then 0xAABBCCDD with strb 0101 -> bytes 0,2 new
    wq = '{32'h1122_3344};
    write_burst(28'h20, 4'd0, 4'd1, 4'hF, -1, 0);
    wq = '{32'hAABB_CCDD};
    write_burst(28'h20, 4'd0, 4'd3, 4'b0101, -1, 0);
    exp_q = '{32'h11BB_33DD};
    read_burst(28'h20, 4'd0, 4'd4);

    // wstrb=0 still completes the beat but changes nothing
    wq = '{32'h5555_5555};
    write_burst(28'h20, 4'd0, 4'd6, 4'h0, -1, 0);
    exp_q = '{32'h11BB_33DD};
    read_burst(28'h20, 4'd0, 4'd6);

    // wrap at the top of memory
    wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    write_burst(28'(DEPTH - 2), 4'd3, 4'd7, 4'hF, -1, 0);
    exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    read_burst(28'(DEPTH - 2), 4'd3, 4'd8);
    exp_q = '{32'hA2, 32'hA3};
    read_burst(28'h0, 4'd1, 4'd9);

    // high address bits ignored, single-beat read
    exp_q = '{32'h3};
    read_burst(28'hABC_0012, 4'd0, 4'hA);

    // wvalid dropped 3 cycles mid-burst
    wq = '{32'h50, 32'h51, 32'h52, 32'h53};
    write_burst(28'h40, 4'd3, 4'd9, 4'hF, 2, 3);
    exp_q = '{32'h50, 32'h51, 32'h52, 32'h53};
    read_burst(28'h40, 4'd3, 4'hB);

    // reset in the middle of a read burst
    araddr = 28'h10; arlen = 4'd3; aruser_id = 4'hC; arvalid = 1'b1;
    #1;
    check("rst_rd_arready", arready, 1'b1);
    tick();
    arvalid = 1'b0;
    tick();
    check("rst_rd_rvalid_pre", rvalid, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_rd_rvalid", rvalid, 1'b0);
    check("rst_rd_rlast", rlast, 1'b0);
    check("rst_rd_state", dbg_state, IDLE);
    tick();
    rst = 1'b0;
    tick();
    exp_q = '{32'h1, 32'h2, 32'h3, 32'h4};
    read_burst(28'h10, 4'd3, 4'hD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
